// File: rtl/cordic_iter_ctrl.sv
// CORDIC iteration sequencer: owns the Z (angle) accumulator and steps the atan table index.
// Latency: Start edge -> LoadXY next cycle -> ITER cycles of IterEn -> Done from cycle ITER+2.
// No backpressure beyond the Start/Done/Ack handshake; Start is ignored unless idle.
module cordic_iter_ctrl #(
  parameter int ITER    = 8,
  parameter int ANGLE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic signed [ANGLE_W-1:0] target,
  input  logic        [ANGLE_W-1:0] thetai,
  input  logic                      ack,
  output logic        [2:0]         count3,
  output logic                      loadxy,
  output logic                      iteren,
  output logic                      sigma,
  output logic                      busy,
  output logic                      done,
  output logic signed [ANGLE_W:0]   zres
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_DONE
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(ITER - 1);

  state_t                   state;
  logic signed [ANGLE_W:0]  z;
  logic signed [ANGLE_W:0]  theta_ext;
  logic signed [ANGLE_W:0]  z_step;

  // Table constant is unsigned; the extra Z bit absorbs the sign without saturation.
  assign theta_ext = {1'b0, thetai};
  assign sigma     = ~z[ANGLE_W];
  assign z_step    = sigma ? (z - theta_ext) : (z + theta_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      count3 <= '0;
      loadxy <= 1'b0;
      iteren <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      z      <= '0;
      zres   <= '0;
    end else if (abort) begin
      // Z and ZRes are deliberately left as they were.
      state  <= S_IDLE;
      count3 <= '0;
      loadxy <= 1'b0;
      iteren <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_LOAD;
            z      <= {target[ANGLE_W-1], target};
            count3 <= '0;
            loadxy <= 1'b1;
            busy   <= 1'b1;
          end
        end
        S_LOAD: begin
          state  <= S_ITER;
          loadxy <= 1'b0;
          iteren <= 1'b1;
        end
        S_ITER: begin
          z <= z_step;
          if (count3 == LAST_IDX) begin
            state  <= S_DONE;
            count3 <= '0;
            iteren <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            zres   <= z_step;
          end else begin
            count3 <= count3 + 3'd1;
          end
        end
        S_DONE: begin
          // Ack wins over a coincident Start; a fresh Start is needed in IDLE.
          if (ack) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Randomized bench for cordic_iter_ctrl against a plain-arithmetic CORDIC Z-path model.
// The bench plays the atan table generator (64 = 45 degrees, sum 141).
module tb_cordic_iter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] target = '0;
  logic [7:0] thetai;
  logic [2:0] count3;
  logic       loadxy, iteren, sigma, busy, done;
  logic [8:0] zres;

  int n_checks = 0;
  int n_fail   = 0;
  int tbl[8] = '{64, 38, 20, 10, 5, 3, 1, 0};

  always #5 clk = ~clk;

  assign thetai = 8'(tbl[count3]);

  cordic_iter_ctrl #(.ITER(8), .ANGLE_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .target (target),
    .thetai (thetai),
    .ack    (ack),
    .count3 (count3),
    .loadxy (loadxy),
    .iteren (iteren),
    .sigma  (sigma),
    .busy   (busy),
    .done   (done),
    .zres   (zres)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Greedy rotation toward zero, 9-bit wrap; returns residual and per-iteration direction.
  function automatic logic [8:0] model_z(input logic [7:0] tgt, output logic [7:0] sg);
    int z;
    z = $signed(tgt);
    sg = '0;
    for (int i = 0; i < 8; i++) begin
      sg[i] = (z >= 0);
      z = sg[i] ? z - tbl[i] : z + tbl[i];
      z = z & 511;
      if (z >= 256) z = z - 512;
    end
    return z[8:0];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_loadxy"}, 32'(loadxy), 32'd0);
    check({tag, "_iteren"}, 32'(iteren), 32'd0);
    check({tag, "_busy"},   32'(busy),   32'd0);
    check({tag, "_done"},   32'(done),   32'd0);
    check({tag, "_count3"}, 32'(count3), 32'd0);
  endtask

  // Issues one operation from IDLE and checks every cycle up to Done (or abort).
  task automatic run_op(input logic [7:0] tgt, input int poke_at, input int abort_at,
                        output logic [7:0] sig_obs, output logic [8:0] z_obs);
    logic [7:0] es;
    logic [8:0] ez;
    ez = model_z(tgt, es);
    sig_obs = '0;
    z_obs = '0;
    @(negedge clk);
    start = 1'b1;
    target = tgt;
    @(negedge clk);
    start = 1'b0;
    target = 8'($urandom);
    check("load_strobe", 32'(loadxy), 32'd1);
    check("load_busy",   32'(busy),   32'd1);
    check("load_iteren", 32'(iteren), 32'd0);
    check("load_done",   32'(done),   32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = (i == poke_at);
      check("iter_en",     32'(iteren), 32'd1);
      check("iter_count3", 32'(count3), 32'(i));
      check("iter_sigma",  32'(sigma),  32'(es[i]));
      check("iter_loadxy", 32'(loadxy), 32'd0);
      check("iter_busy",   32'(busy),   32'd1);
      check("iter_done",   32'(done),   32'd0);
      sig_obs[i] = sigma;
      if (i == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle_outputs("abort");
        repeat (12) begin
          @(negedge clk);
          check("abort_no_done", 32'(done), 32'd0);
        end
        return;
      end
    end
    start = 1'b0;
    @(negedge clk);
    check("done_set",    32'(done),   32'd1);
    check("done_busy",   32'(busy),   32'd0);
    check("done_iteren", 32'(iteren), 32'd0);
    check("done_count3", 32'(count3), 32'd0);
    check("zres_model",  32'(zres),   32'(ez));
    z_obs = zres;
  endtask

  task automatic release_done(input int hold);
    logic [8:0] z0;
    z0 = zres;
    repeat (hold) begin
      @(negedge clk);
      check("hold_done", 32'(done), 32'd1);
      check("hold_zres", 32'(zres), 32'(z0));
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("ack_done_drop", 32'(done), 32'd0);
  endtask

  logic [7:0] s;
  logic [8:0] z;

  initial begin
    #12;
    check_idle_outputs("reset");
    check("reset_zres", 32'(zres), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero target: known direction pattern and residual +1.
    run_op(8'd0, -1, -1, s, z);
    check("t0_sigma_seq", 32'(s), 32'h0D1);
    check("t0_zres", 32'(z), 32'h001);
    repeat (5) begin
      @(negedge clk);
      check("t0_hold_done", 32'(done), 32'd1);
      check("t0_hold_zres", 32'(zres), 32'h001);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_done",   32'(done),   32'd1);
    check("start_in_done_loadxy", 32'(loadxy), 32'd0);
    ack = 1'b1;
    start = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    start = 1'b0;
    check("ack_start_done", 32'(done), 32'd0);
    @(negedge clk);
    check("ack_start_no_load", 32'(loadxy), 32'd0);
    check("ack_start_no_busy", 32'(busy),   32'd0);

    // 45 degrees: residual -1.
    run_op(8'd64, -1, -1, s, z);
    check("t64_sigma_seq", 32'(s), 32'h043);
    check("t64_zres", 32'(z), 32'h1FF);
    release_done(0);

    // Most negative target, with a Start poke mid-iteration.
    run_op(8'h80, 3, -1, s, z);
    check("tneg_first_sigma", 32'(s[0]), 32'd0);
    check("tneg_second_sigma", 32'(s[1]), 32'd0);
    check("tneg_zres_range", 32'($signed(z) >= -1 && $signed(z) <= 1), 32'd1);
    release_done(2);

    // Abort at index 3, then a clean run.
    run_op(8'(40), -1, 3, s, z);
    run_op(8'(100), -1, -1, s, z);
    release_done(1);

    // Asynchronous reset mid-iteration, off the clock edge.
    @(negedge clk);
    start = 1'b1;
    target = 8'(50);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_zres", 32'(zres), 32'd0);
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_idle_outputs("post_rst");
    end

    // Randomized operations.
    for (int k = 0; k < 24; k++) begin
      int poke;
      poke = (k % 3 == 0) ? int'($urandom_range(0, 7)) : -1;
      run_op(8'($urandom), poke, -1, s, z);
      release_done(int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
- Iteration sequencer for the CORDIC rotation core; owns the angle accumulator (Z path).
- Accepts a target angle with a Start/Done/Ack handshake and drives the 3-bit iteration index into the arctangent table generator.
- Consumes the table's angle constant and issues per-iteration load, enable and direction (Sigma) strobes to the X/Y shift-add datapath.
- Returns the residual angle on completion.

Parameters:
- ITER, 8, number of micro-rotations per operation; legal range 1..8 because the index is 3 bits.
- ANGLE_W, 8, angle width in bits; signed two's complement, 64 = 45 degrees.

Ports:
- Clk  input  1  single system clock, rising edge.
- Rst_n  input  1  asynchronous reset, active low.
- Start  input  1  request a new operation; sampled only in IDLE.
- Abort  input  1  synchronous abort; returns to IDLE from any state.
- Target  input  ANGLE_W  signed target angle; captured on the accepted Start.
- Thetai  input  ANGLE_W  unsigned table constant for the current Count3; combinational return from the table generator.
- Ack  input  1  result consumed; releases DONE.
- Count3  output  3  iteration index to the table generator.
- LoadXY  output  1  one-cycle strobe: X/Y datapath loads its initial vector.
- IterEn  output  1  X/Y datapath performs one micro-rotation this cycle.
- Sigma  output  1  direction for the current iteration: 1 = rotate positive (Z decreases), 0 = negative.
- Busy  output  1  high in LOAD and ITER.
- Done  output  1  result valid; held until Ack.
- ZRes  output  ANGLE_W+1  signed residual angle; valid while Done is high.

Behaviour:
- Reset (Rst_n low, asynchronous) values:
  - State = IDLE.
  - Count3, LoadXY, IterEn, Busy, Done = 0.
  - Internal Z = 0; ZRes = 0.
  - Reset asserted mid-operation discards all work immediately.
- Internal Z register is ANGLE_W+1 bits, signed. Target is sign-extended into it. Thetai is zero-extended. Adds and subtracts wrap with no saturation; the table sum (141) keeps in-range targets from overflowing.
- Sigma = ~Z[ANGLE_W], combinational from the Z register, so it is 1 when Z >= 0. Sigma is meaningful only while IterEn = 1.
- FSM states and transitions:
  - IDLE: wait for Start. Start = 1 -> LOAD, and capture Z <= sext(Target). Start = 0 -> stay.
  - LOAD (1 cycle): LoadXY = 1, Busy = 1, Count3 = 0 -> ITER.
  - ITER (ITER cycles): IterEn = 1, Busy = 1.
    - Each cycle: Z <= Sigma ? Z - Thetai : Z + Thetai.
    - If Count3 == ITER-1 -> DONE, and Count3 <= 0. Otherwise Count3 <= Count3 + 1.
  - DONE: Done = 1, ZRes = Z (registered on entry), Busy = 0. Ack = 1 -> IDLE, with Done dropping the following cycle.
- Latency: Start sampled at edge 0 -> LoadXY high cycle 1 -> IterEn high cycles 2..ITER+1 -> Done high from cycle ITER+2.
- Start outside IDLE is ignored; no queuing. Start with Ack in DONE is also ignored: Ack wins and a new Start is needed in IDLE.
- Abort has priority over every transition. It returns to IDLE next edge and clears LoadXY, IterEn, Busy, Done and Count3. Z and ZRes are left unchanged.
- Ack outside DONE has no effect.
- Count3 changes only on clock edges, giving the table generator a full cycle to settle before Z updates.

Test Plan:
- Reset: hold Rst_n low mid-ITER, asynchronously, not aligned to a clock edge -> all outputs 0 immediately, state IDLE; release -> no spurious LoadXY.
- Target = 0, ITER = 8 -> Sigma per iteration 1,0,0,0,1,0,1,1; Count3 0..7; ZRes = +1 at Done; Done first seen 10 cycles after the Start edge.
- Target = 64 -> Sigma 1,1,0,0,0,0,1,0; ZRes = -1 (9'h1FF).
- Target = -128 -> first Sigma = 0, Z after iteration 0 = -64; run to completion and check ZRes against a bench model in the range -1..+1.
- Handshake: hold Ack low 5 cycles -> Done and ZRes stable. Pulse Start during ITER and DONE -> ignored. Assert Ack and Start together -> return to IDLE, no new operation. Start one cycle later -> new LOAD.
- Abort at Count3 = 3 -> IDLE next cycle, IterEn = 0, Done never asserted. Next Start runs a full clean operation with the correct ZRes.
